down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

- Loadable down-counter with a small control FSM. It is the counting-down counterpart of the team's up-counter.
- The up-counter counts up from zero and flags all-ones through `cout`. This block starts from a loaded value, counts down to zero and flags zero through `bout`.
- It raises a one-cycle `done` pulse at terminal count and can optionally reload itself for periodic operation.
- It drives timeouts and fixed-length phases in the datapath controllers, alongside the up-counters.

## Interface
Parameters:
- `n`, 6, counter width in bits.

Ports:
- `clock`, in, 1, rising-edge clock.
- `reset`, in, 1, asynchronous, active-low. Low forces reset state immediately.
- `clear`, in, 1, synchronous abort. Highest priority after reset.
- `start`, in, 1, load `load_value` and begin counting. Honored only in IDLE.
- `load_value`, in, n, initial and reload count. Sampled when `start` is honored.
- `enable`, in, 1, decrement qualifier. Low in RUN pauses the count.
- `auto_reload`, in, 1, at terminal count: 1 reloads and keeps running, 0 stops. Sampled at the terminal edge.
- `p_out`, out, n, current count (registered).
- `bout`, out, 1, combinational `p_out == 0`.
- `busy`, out, 1, high in RUN.
- `done`, out, 1, registered one-cycle terminal-count pulse.

## Operation
- States: IDLE and RUN.
- Priority per edge: `clear` > `start` > `enable`.
- A reload register holds the `load_value` captured on the last honored `start`.

IDLE:
- `start` with `load_value != 0`: `p_out <= load_value`, reload register <= `load_value`, go to RUN.
- `start` with `load_value == 0`: `p_out <= 0`, `done <= 1` for one cycle, stay in IDLE.
- Otherwise `p_out` holds.

RUN:
- `enable=0`: hold `p_out` and stay in RUN.
- `enable=1` and `p_out > 1`: `p_out <= p_out - 1`.
- `enable=1` and `p_out == 1` (terminal edge): `done <= 1`.
  - If `auto_reload=1`: `p_out <= reload register`, stay in RUN.
  - Else: `p_out <= 0`, go to IDLE.
- `start` in RUN is ignored. It does not restart or reload the count.

`clear` (any state):
- `p_out <= 0`, go to IDLE, `done <= 0`.
- Reload register unchanged.
- Overrides a coincident terminal edge: no `done` pulse.

Arithmetic and width rules:
- Decrement is modulo 2^n.
- `p_out` never wraps from 0 to all-ones, because RUN always holds `p_out >= 1`.
- `load_value` of all-ones, (2^n)-1, is legal and gives the longest count.

Reset (`reset` low):
- `p_out = 0`, state IDLE, `done = 0`, `busy = 0`, reload register = 0.
- `bout = 1` during and after reset.
- Reset mid-count abandons the count with no `done` pulse.

## Timing
- Load latency: `start` honored at edge t gives `p_out = L` and `busy = 1` from edge t onward.
- Count length: `done` asserts after exactly L enabled edges following the load edge. Pauses extend the wall time only.
- The cycle in which `done = 1` shows `p_out = 0` (and `busy = 0`, `bout = 1`), or the reload value L if reloading.
- Periodic mode with `enable` held high: `done` pulses every L cycles.
- A new `start` is accepted in the cycle immediately after a non-reload terminal, i.e. while `done` is high.
- `done` is never high for two consecutive cycles, except with `auto_reload` and L = 1, where it stays high continuously.

## Structure
- Shared package holds:
  - state enum (IDLE, RUN), 1-bit encoding;
  - default width constant, 6, shared with the up-counter.
- No sub-module. One registered always block for state, count and reload register, plus combinational `bout` and `busy`.

## Test plan
- **Basic count, n=6:** reset released; `start` with `load_value=5`, `enable=1`, `auto_reload=0` -> `p_out` = 5,4,3,2,1,0; `done` high exactly once, in the cycle `p_out` first reads 0; `busy` falls in that same cycle.
- **Pause:** `load_value=3`, `enable` low for 4 cycles after the first decrement -> `p_out` holds at 2 throughout; `done` appears 4 cycles later than in the unpaused run.
- **Periodic reload:** `load_value=4`, `auto_reload=1`, `enable=1` for 20 cycles -> `done` pulses every 4 cycles; `p_out` sequence is 4,3,2,1,4,3,...; `busy` stays high.
- **Zero load and ignored start:**
  - `start` with `load_value=0` -> one-cycle `done`, `busy` stays 0, `p_out=0`.
  - `start` with `load_value=9` while in RUN at `p_out=6` -> no effect on `p_out`.
- **Clear collision:** `clear` asserted on the terminal edge with `p_out=1` -> `p_out=0`, state IDLE, no `done` pulse.
- **Async reset mid-count:** `reset` driven low between edges while `p_out=37` (`load_value=63`) -> immediately `p_out=0`, `busy=0`, `bout=1`, `done=0`; after release, `start` with `load_value=63` counts the full 63 edges.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down_counter_timer block: controller state type and
// the default counter width used by both the down- and up-counters.
package down_counter_timer_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control and status bundle of the down_counter_timer; the controller drives it
// through the master modport, and the timer answers through the slave modport.
interface down_counter_timer_if
    import down_counter_timer_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
);

    logic         clear;
    logic         start;
    logic [n-1:0] load_value;
    logic         enable;
    logic         auto_reload;
    logic [n-1:0] p_out;
    logic         bout;
    logic         busy;
    logic         done;

    modport master (
        output clear, start, load_value, enable, auto_reload,
        input  p_out, bout, busy, done
    );

    modport slave (
        input  clear, start, load_value, enable, auto_reload,
        output p_out, bout, busy, done
    );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with IDLE/RUN control, one-cycle terminal-count pulse and
// optional self-reload for periodic operation.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    down_counter_timer_if.slave bus
);

    state_t       state_p0;
    state_t       state_nxt;
    logic [n-1:0] count_p0;
    logic [n-1:0] count_nxt;
    logic [n-1:0] reload_p0;
    logic [n-1:0] reload_nxt;
    logic         done_p0;
    logic         done_nxt;

    always_comb begin
        state_nxt  = state_p0;
        count_nxt  = count_p0;
        reload_nxt = reload_p0;
        done_nxt   = 1'b0;
        if (bus.clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (bus.start) begin
                        count_nxt = bus.load_value;
                        if (bus.load_value != '0) begin
                            reload_nxt = bus.load_value;
                            state_nxt  = RUN;
                        end else begin
                            // Zero-length count finishes on the load edge itself.
                            done_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        // RUN always holds count >= 1, so 1 is the only terminal value.
                        if (count_p0 == n'(1)) begin
                            done_nxt = 1'b1;
                            if (bus.auto_reload) begin
                                count_nxt = reload_p0;
                            end else begin
                                count_nxt = '0;
                                state_nxt = IDLE;
                            end
                        end else begin
                            count_nxt = count_p0 - n'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // Stage p0: single register stage for state, count, reload value and done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_p0  <= IDLE;
            count_p0  <= '0;
            reload_p0 <= '0;
            done_p0   <= 1'b0;
        end else begin
            state_p0  <= state_nxt;
            count_p0  <= count_nxt;
            reload_p0 <= reload_nxt;
            done_p0   <= done_nxt;
        end
    end

    assign bus.p_out = count_p0;
    assign bus.bout  = (count_p0 == '0);
    assign bus.busy  = (state_p0 == RUN);
    assign bus.done  = done_p0;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed testbench for down_counter_timer: hand-computed count sequences,
// pause, periodic reload, zero load, ignored start, clear collision, async reset.
module tb_down_counter_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    down_counter_timer_if #(.n(6)) bus ();

    down_counter_timer #(.n(6)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input int p, input bit d, input bit b);
        check({tag, ".p_out"}, 32'(bus.p_out), 32'(p));
        check({tag, ".done"},  32'(bus.done),  32'(d));
        check({tag, ".busy"},  32'(bus.busy),  32'(b));
        check({tag, ".bout"},  32'(bus.bout),  32'(p == 0));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.clear       = 1'b0;
        bus.start       = 1'b0;
        bus.load_value  = '0;
        bus.enable      = 1'b0;
        bus.auto_reload = 1'b0;

        // Reset state
        step();
        step();
        status("reset", 0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        status("post_reset", 0, 1'b0, 1'b0);

        // Basic count, L=5
        bus.load_value = 6'd5;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        step();
        status("basic_load", 5, 1'b0, 1'b1);
        bus.start = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            step();
            status("basic_cnt", i, 1'b0, 1'b1);
        end
        step();
        status("basic_term", 0, 1'b1, 1'b0);
        step();
        status("basic_after", 0, 1'b0, 1'b0);

        // Pause, L=3, four paused cycles after the first decrement
        bus.load_value = 6'd3;
        bus.start      = 1'b1;
        step();
        status("pause_load", 3, 1'b0, 1'b1);
        bus.start = 1'b0;
        step();
        status("pause_dec", 2, 1'b0, 1'b1);
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            status("pause_hold", 2, 1'b0, 1'b1);
        end
        bus.enable = 1'b1;
        step();
        status("pause_resume", 1, 1'b0, 1'b1);
        step();
        status("pause_term", 0, 1'b1, 1'b0);

        // Periodic reload, L=4, accepted while previous done is high
        bus.load_value  = 6'd4;
        bus.auto_reload = 1'b1;
        bus.start       = 1'b1;
        step();
        status("periodic_load", 4, 1'b0, 1'b1);
        bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            status("periodic", 4 - (i % 4), (i % 4) == 0, 1'b1);
        end
        bus.clear = 1'b1;
        step();
        status("periodic_clear", 0, 1'b0, 1'b0);
        bus.clear       = 1'b0;
        bus.auto_reload = 1'b0;

        // Zero load
        bus.load_value = 6'd0;
        bus.start      = 1'b1;
        step();
        status("zero_load", 0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        status("zero_after", 0, 1'b0, 1'b0);

        // Start ignored in RUN at p_out=6
        bus.load_value = 6'd10;
        bus.start      = 1'b1;
        step();
        status("ign_load", 10, 1'b0, 1'b1);
        bus.start = 1'b0;
        for (int i = 9; i >= 6; i--) begin
            step();
            status("ign_cnt", i, 1'b0, 1'b1);
        end
        bus.load_value = 6'd9;
        bus.start      = 1'b1;
        step();
        status("ign_start", 5, 1'b0, 1'b1);
        bus.start = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            step();
            status("ign_cnt2", i, 1'b0, 1'b1);
        end

        // Clear on the terminal edge suppresses done
        bus.clear = 1'b1;
        step();
        status("clear_term", 0, 1'b0, 1'b0);
        bus.clear = 1'b0;
        step();
        status("clear_after", 0, 1'b0, 1'b0);

        // Async reset mid-count at p_out=37, L=63
        bus.load_value = 6'd63;
        bus.start      = 1'b1;
        step();
        status("rst_load", 63, 1'b0, 1'b1);
        bus.start = 1'b0;
        repeat (26) step();
        status("rst_pre", 37, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        status("rst_async", 0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        status("rst_released", 0, 1'b0, 1'b0);

        // Full-length count after reset
        bus.start = 1'b1;
        step();
        status("full_load", 63, 1'b0, 1'b1);
        bus.start = 1'b0;
        for (int i = 1; i <= 62; i++) begin
            step();
            status("full_cnt", 63 - i, 1'b0, 1'b1);
        end
        step();
        status("full_term", 0, 1'b1, 1'b0);
        step();
        status("full_after", 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
